// File: rtl/addr_seq_if.sv
// addr_seq control/status bundle: config and strobes in from the register block, ROM address and pulses out.
// The rev field exists only when ADDR_SEQ_REV_EN is defined.
interface addr_seq_if #(
  parameter int ADDR_W = 8,
  parameter int RPT_W  = 4
);
  logic              tick;
  logic              start;
  logic              stop;
  logic              loop_mode;
  logic [RPT_W-1:0]  rpt_cnt;
  logic [ADDR_W-1:0] addr_start;
  logic [ADDR_W-1:0] addr_finish;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              at_finish;
  logic              wrap;
  logic              done;
  logic              cfg_err;
`ifdef ADDR_SEQ_REV_EN
  logic              rev;
`endif

  modport master (
`ifdef ADDR_SEQ_REV_EN
    output rev,
`endif
    output tick, start, stop, loop_mode, rpt_cnt, addr_start, addr_finish,
    input  addr, busy, at_finish, wrap, done, cfg_err
  );

  modport slave (
`ifdef ADDR_SEQ_REV_EN
    input  rev,
`endif
    input  tick, start, stop, loop_mode, rpt_cnt, addr_start, addr_finish,
    output addr, busy, at_finish, wrap, done, cfg_err
  );
endinterface

// File: rtl/addr_seq.sv
// addr_seq: ROM address sequencer over [start..finish], one-shot / N-repeat / loop; ADDR_SEQ_REV_EN adds descending playback.
// Latency: addr and all pulses registered, one cycle after the causing edge; no backpressure, steps only on tick.
module addr_seq #(
  parameter int ADDR_W = 8,
  parameter int RPT_W  = 4
) (
  input  logic      clk,
  input  logic      rst,
  addr_seq_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] start_sh;
  logic [ADDR_W-1:0] finish_sh;
  logic [ADDR_W-1:0] end_sh;
  logic [ADDR_W-1:0] restart_sh;
  logic [ADDR_W-1:0] next_addr;
  logic [RPT_W-1:0]  rpt_sh;
  logic [RPT_W-1:0]  pass_cnt;
  logic              loop_sh;
  logic              wrap_q;
  logic              done_q;
  logic              cfg_err_q;
  logic              cfg_bad;

  assign cfg_bad = bus.addr_start > bus.addr_finish;

`ifdef ADDR_SEQ_REV_EN
  logic rev_sh;
  // Descending playback swaps roles: start ends a pass, finish is where it restarts.
  assign end_sh     = rev_sh ? start_sh  : finish_sh;
  assign restart_sh = rev_sh ? finish_sh : start_sh;
  assign next_addr  = rev_sh ? addr_q - 1'b1 : addr_q + 1'b1;
`else
  assign end_sh     = finish_sh;
  assign restart_sh = start_sh;
  assign next_addr  = addr_q + 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      start_sh  <= '0;
      finish_sh <= '0;
      rpt_sh    <= '0;
      loop_sh   <= 1'b0;
      pass_cnt  <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef ADDR_SEQ_REV_EN
      rev_sh    <= 1'b0;
`endif
    end else begin
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (bus.stop && state == RUN) begin
        state <= IDLE;
      end else if (bus.start) begin
        if (cfg_bad) begin
          state     <= IDLE;
          cfg_err_q <= 1'b1;
        end else begin
          start_sh  <= bus.addr_start;
          finish_sh <= bus.addr_finish;
          rpt_sh    <= bus.rpt_cnt;
          loop_sh   <= bus.loop_mode;
          pass_cnt  <= '0;
          state     <= RUN;
`ifdef ADDR_SEQ_REV_EN
          rev_sh    <= bus.rev;
          addr_q    <= bus.rev ? bus.addr_finish : bus.addr_start;
`else
          addr_q    <= bus.addr_start;
`endif
        end
      end else if (state == RUN && bus.tick) begin
        // Wrap is taken before any step at the pass end, so addr never overflows.
        if (addr_q != end_sh) begin
          addr_q <= next_addr;
        end else if (loop_sh || pass_cnt < rpt_sh) begin
          if (!loop_sh) begin
            pass_cnt <= pass_cnt + 1'b1;
          end
          addr_q <= restart_sh;
          wrap_q <= 1'b1;
        end else begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.addr      = addr_q;
  assign bus.busy      = (state == RUN);
  assign bus.at_finish = (state == RUN) && (addr_q == end_sh);
  assign bus.wrap      = wrap_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_addr_seq.sv
// Directed bench for addr_seq: an 8-bit and a 4-bit instance, expectations queued per step and checked after each edge.
module tb_addr_seq;
  logic clk;
  logic rst;

  addr_seq_if #(.ADDR_W(8), .RPT_W(4)) b8 ();
  addr_seq_if #(.ADDR_W(4), .RPT_W(4)) b4 ();

  addr_seq #(.ADDR_W(8), .RPT_W(4)) u8 (.clk(clk), .rst(rst), .bus(b8));
  addr_seq #(.ADDR_W(4), .RPT_W(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct {
    string      tag;
    logic [7:0] addr;
    logic       busy;
    logic       atf;
    logic       wrap;
    logic       done;
    logic       cerr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp1(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed %h expected %h", tag, fld, obs, exp);
    end
  endtask

  task automatic check(input int sel);
    exp_t e;
    logic [7:0] a;
    logic b, af, w, d, c;
    if (sel == 1) begin
      a = {4'h0, b4.addr}; b = b4.busy; af = b4.at_finish; w = b4.wrap; d = b4.done; c = b4.cfg_err;
    end else begin
      a = b8.addr; b = b8.busy; af = b8.at_finish; w = b8.wrap; d = b8.done; c = b8.cfg_err;
    end
    e = sb.pop_front();
    cmp1(e.tag, "addr", a, e.addr);
    cmp1(e.tag, "busy", {7'd0, b}, {7'd0, e.busy});
    cmp1(e.tag, "at_finish", {7'd0, af}, {7'd0, e.atf});
    cmp1(e.tag, "wrap", {7'd0, w}, {7'd0, e.wrap});
    cmp1(e.tag, "done", {7'd0, d}, {7'd0, e.done});
    cmp1(e.tag, "cfg_err", {7'd0, c}, {7'd0, e.cerr});
  endtask

  task automatic push(input string tag, input logic [7:0] a, input logic b, input logic af,
                      input logic w, input logic d, input logic c);
    exp_t e;
    e.tag = tag; e.addr = a; e.busy = b; e.atf = af; e.wrap = w; e.done = d; e.cerr = c;
    sb.push_back(e);
  endtask

  // Check current outputs without a clock edge (reset behaviour).
  task automatic chk(input int sel, input string tag, input logic [7:0] a, input logic b,
                     input logic af, input logic w, input logic d, input logic c);
    push(tag, a, b, af, w, d, c);
    check(sel);
  endtask

  // Apply the currently driven inputs across one edge, drop the strobes, then check.
  task automatic cyc(input int sel, input string tag, input logic [7:0] a, input logic b,
                     input logic af, input logic w, input logic d, input logic c);
    push(tag, a, b, af, w, d, c);
    @(posedge clk);
    #1;
    b8.start = 1'b0; b8.stop = 1'b0;
    b4.start = 1'b0; b4.stop = 1'b0;
    check(sel);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    rst = 1'b1;
    b8.tick = 0; b8.start = 0; b8.stop = 0; b8.loop_mode = 0; b8.rpt_cnt = 0;
    b8.addr_start = 0; b8.addr_finish = 0;
    b4.tick = 0; b4.start = 0; b4.stop = 0; b4.loop_mode = 0; b4.rpt_cnt = 0;
    b4.addr_start = 0; b4.addr_finish = 0;
`ifdef ADDR_SEQ_REV_EN
    b8.rev = 0; b4.rev = 0;
`endif
    #1;
    chk(0, "rst8", 8'h00, 0, 0, 0, 0, 0);
    chk(1, "rst4", 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, "idle", 8'h00, 0, 0, 0, 0, 0);

    // one-shot 10..13
    b8.addr_start = 8'h10; b8.addr_finish = 8'h13; b8.loop_mode = 0; b8.rpt_cnt = 0;
    b8.tick = 1; b8.start = 1;
    cyc(0, "t1_a10", 8'h10, 1, 0, 0, 0, 0);
    cyc(0, "t1_a11", 8'h11, 1, 0, 0, 0, 0);
    cyc(0, "t1_a12", 8'h12, 1, 0, 0, 0, 0);
    cyc(0, "t1_a13", 8'h13, 1, 1, 0, 0, 0);
    cyc(0, "t1_done", 8'h13, 0, 0, 0, 1, 0);
    cyc(0, "t1_hold", 8'h13, 0, 0, 0, 0, 0);

    // three passes 20..21
    b8.addr_start = 8'h20; b8.addr_finish = 8'h21; b8.rpt_cnt = 2; b8.start = 1;
    cyc(0, "t2_p0a", 8'h20, 1, 0, 0, 0, 0);
    cyc(0, "t2_p0b", 8'h21, 1, 1, 0, 0, 0);
    cyc(0, "t2_p1a", 8'h20, 1, 0, 1, 0, 0);
    cyc(0, "t2_p1b", 8'h21, 1, 1, 0, 0, 0);
    cyc(0, "t2_p2a", 8'h20, 1, 0, 1, 0, 0);
    cyc(0, "t2_p2b", 8'h21, 1, 1, 0, 0, 0);
    cyc(0, "t2_done", 8'h21, 0, 0, 0, 1, 0);
    cyc(0, "t2_hold", 8'h21, 0, 0, 0, 0, 0);

    // loop 05..06, tick every third cycle; config changed mid-run must be ignored
    b8.addr_start = 8'h05; b8.addr_finish = 8'h06; b8.loop_mode = 1; b8.rpt_cnt = 0;
    b8.tick = 0; b8.start = 1;
    cyc(0, "t3_start", 8'h05, 1, 0, 0, 0, 0);
    b8.addr_finish = 8'h80; b8.loop_mode = 0;
    cur = 8'h05;
    for (int k = 0; k < 4; k++) begin
      b8.tick = 0;
      cyc(0, "t3_idle1", cur, 1, cur == 8'h06, 0, 0, 0);
      cyc(0, "t3_idle2", cur, 1, cur == 8'h06, 0, 0, 0);
      b8.tick = 1;
      nxt = (cur == 8'h06) ? 8'h05 : 8'h06;
      cyc(0, "t3_step", nxt, 1, nxt == 8'h06, cur == 8'h06, 0, 0);
      cur = nxt;
    end
    b8.stop = 1;
    cyc(0, "t3_stop", 8'h05, 0, 0, 0, 0, 0);
    cyc(0, "t3_frozen", 8'h05, 0, 0, 0, 0, 0);

    // rejected start from IDLE
    b8.addr_start = 8'h30; b8.addr_finish = 8'h2F; b8.start = 1;
    cyc(0, "t4_cerr", 8'h05, 0, 0, 0, 0, 1);
    cyc(0, "t4_after", 8'h05, 0, 0, 0, 0, 0);

    // start and stop together while running: stop wins
    b8.addr_start = 8'h10; b8.addr_finish = 8'h11; b8.loop_mode = 1; b8.tick = 0; b8.start = 1;
    cyc(0, "t4_run", 8'h10, 1, 0, 0, 0, 0);
    b8.addr_start = 8'h20; b8.addr_finish = 8'h21; b8.start = 1; b8.stop = 1;
    cyc(0, "t4_stopwin", 8'h10, 0, 0, 0, 0, 0);

    // rejected start while running drops to IDLE, addr unchanged
    b8.addr_start = 8'h10; b8.addr_finish = 8'h11; b8.start = 1;
    cyc(0, "t4_run2", 8'h10, 1, 0, 0, 0, 0);
    b8.addr_start = 8'h30; b8.addr_finish = 8'h2F; b8.start = 1;
    cyc(0, "t4_cerr_run", 8'h10, 0, 0, 0, 0, 1);

    // 4-bit instance at the top of the address space, two passes
    b4.addr_start = 4'hE; b4.addr_finish = 4'hF; b4.loop_mode = 0; b4.rpt_cnt = 1;
    b4.tick = 1; b4.start = 1;
    cyc(1, "t5_e0", 8'h0E, 1, 0, 0, 0, 0);
    cyc(1, "t5_f0", 8'h0F, 1, 1, 0, 0, 0);
    cyc(1, "t5_e1", 8'h0E, 1, 0, 1, 0, 0);
    cyc(1, "t5_f1", 8'h0F, 1, 1, 0, 0, 0);
    cyc(1, "t5_done", 8'h0F, 0, 0, 0, 1, 0);

    // async reset mid-run
    b4.loop_mode = 1; b4.start = 1;
    cyc(1, "t5_run", 8'h0E, 1, 0, 0, 0, 0);
    cyc(1, "t5_runf", 8'h0F, 1, 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk(1, "t5_arst4", 8'h00, 0, 0, 0, 0, 0);
    chk(0, "t5_arst8", 8'h00, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(1, "t5_noresume", 8'h00, 0, 0, 0, 0, 0);

`ifdef ADDR_SEQ_REV_EN
    b8.rev = 1; b8.addr_start = 8'h40; b8.addr_finish = 8'h42; b8.loop_mode = 0;
    b8.rpt_cnt = 0; b8.tick = 1; b8.start = 1;
    cyc(0, "t6_a42", 8'h42, 1, 0, 0, 0, 0);
    cyc(0, "t6_a41", 8'h41, 1, 0, 0, 0, 0);
    cyc(0, "t6_a40", 8'h40, 1, 1, 0, 0, 0);
    cyc(0, "t6_done", 8'h40, 0, 0, 0, 1, 0);
`endif

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_drain observed %0d leftover expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
